wall_map: RTL and testbench
===========================

// Module: wall_map
// PURPOSE
// Holds the 64x44-cell wall bitmap of the play field and answers the VGA stage's per-grid
// wall lookups (VGA o_request_x/o_request_y -> i_is_wall) with 1-cycle latency.
// Builds a level pattern on request and applies shell-hit wall destruction from game logic.
// Sits directly upstream of VGA. Writes are deferred while VGA is in its active display lines,
// so a frame never tears.
// PARAMETERS
// MAP_W     64  grid columns (H_DISP / 10)
// MAP_H     44  game grid rows (48 display rows minus 4 status-bar rows)
// WQ_DEPTH  4   hit-queue entries (power of 2)
// PORTS
// clk           in   1  system/VGA pixel clock
// rst           in   1  asynchronous reset, active-high
// i_init        in   1  1-cycle pulse: (re)build map for i_level
// i_level       in   2  level pattern select, sampled when i_init=1
// o_ready       out  1  map valid (state RUN)
// i_buzy        in   1  VGA o_buzy; 1 = active display lines, defer writes
// i_request_x   in   6  lookup column (VGA o_request_x)
// i_request_y   in   6  lookup row (VGA o_request_y)
// o_is_wall     out  1  registered wall bit for the previous cycle's request
// i_hit_valid   in   1  destroy request valid
// i_hit_x       in   6  destroy column
// i_hit_y       in   6  destroy row
// o_hit_ready   out  1  queue can accept (valid&ready = push)
// BEHAVIOUR
// - Reset values: state=IDLE; bitmap all 0; queue empty; o_ready=0, o_is_wall=0, o_hit_ready=0.
// - FSM states:
//   - IDLE: on i_init go to BUILD.
//   - BUILD: row counter 0..MAP_H-1 writes one full 64-bit row per cycle from the pattern
//     generator; exactly 44 cycles, then RUN.
//   - RUN: on i_init go to BUILD, row counter to 0, queue flushed.
//   - i_init in BUILD restarts the build at row 0 with the newly sampled level.
// - Patterns (border = x==0 | x==63 | y==0 | y==43, always wall):
//   - 0: border only.
//   - 1: border + columns x=16 and x=47 for y=10..33.
//   - 2: level 1 + row y=22 for x=24..39.
//   - 3: border + cells with x%8==4 and y%8==4.
// - Lookup: o_is_wall <= (state==RUN && i_request_y<MAP_H) ? map[y][x] : 0.
//   Latency 1 clk, valid every cycle. i_request_y>=MAP_H returns 0.
// - o_hit_ready = (state==RUN) && !full. Push when i_hit_valid && o_hit_ready.
// - Pop: at most one entry per cycle, only when state==RUN && !i_buzy && !empty.
//   The popped cell is cleared unless it is a border cell or y>=MAP_H; those are dropped
//   (popped, no write).
// - Push and pop in the same cycle: both occur, count unchanged. Push never occurs when full.
// - A write to cell C in cycle t is visible to a lookup of C issued at t+1.
// - Pointers wrap modulo WQ_DEPTH. Duplicate hits are harmless (clearing is idempotent).
// - rst mid-BUILD or mid-RUN: immediate return to reset values; o_ready=0 until the next
//   i_init plus 44 cycles.
// CONFIGURATION
// WALL_MAP_CNT_EN defined: adds port o_destroyed_cnt (out, 12 bits).
//   - Reset to 0; cleared when BUILD is entered.
//   - +1 on each pop that turns a 1 cell into 0; saturates at 12'hFFF.
// WALL_MAP_CNT_EN undefined: port and counter absent; behaviour otherwise identical.
// TESTING
// 1. rst, i_init with level=0 -> o_ready rises exactly 44 clk after i_init;
//    (0,5)->1, (10,10)->0, (63,43)->1.
// 2. level=1 -> (16,10)=1, (16,9)=0, (47,33)=1; level=3 -> (4,4)=1, (5,4)=0;
//    request y=50 -> 0.
// 3. In RUN, hit (16,20) with i_buzy=1 -> cell stays 1 while buzy; i_buzy falls -> lookup
//    issued next cycle returns 0.
// 4. 5 back-to-back hits with i_buzy=1 -> o_hit_ready=0 after the 4th; the 5th is held
//    until a pop frees a slot.
// 5. Hit (0,12) -> popped, cell remains 1; with WALL_MAP_CNT_EN the count is unchanged,
//    while hit (47,20) -> count +1.
// 6. i_init mid-BUILD and mid-RUN with 2 queued hits -> queue flushed; the new level is
//    complete 44 clk later; rst mid-BUILD -> o_ready=0.

Source files
------------

// File: rtl/wall_map.sv
// Wall bitmap of the 64x44 play field: builds level patterns, answers 1-cycle VGA lookups,
// and clears shell-hit cells outside active display lines. Optional WALL_MAP_CNT_EN adds o_destroyed_cnt.
module wall_map #(
  parameter int MAP_W    = 64,
  parameter int MAP_H    = 44,
  parameter int WQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_init,
  input  logic [1:0]  i_level,
  output logic        o_ready,
  input  logic        i_buzy,
  input  logic [5:0]  i_request_x,
  input  logic [5:0]  i_request_y,
  output logic        o_is_wall,
  input  logic        i_hit_valid,
  input  logic [5:0]  i_hit_x,
  input  logic [5:0]  i_hit_y,
  output logic        o_hit_ready
`ifdef WALL_MAP_CNT_EN
  ,
  output logic [11:0] o_destroyed_cnt
`endif
);

  localparam int PTR_W = $clog2(WQ_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUILD = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  localparam logic [5:0]     X_LAST  = 6'(MAP_W - 1);
  localparam logic [5:0]     Y_LAST  = 6'(MAP_H - 1);
  localparam logic [5:0]     Y_LIM   = 6'(MAP_H);
  localparam logic [PTR_W:0] Q_FULL  = (PTR_W + 1)'(WQ_DEPTH);

  logic [1:0]       state_q, state_d;
  logic [5:0]       row_q, row_d;
  logic [1:0]       level_q, level_d;
  logic [MAP_W-1:0] map_q [MAP_H];
  logic [5:0]       qx_q [WQ_DEPTH];
  logic [5:0]       qy_q [WQ_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             is_wall_q;

  logic       run, full, empty, push, pop, pop_clear;
  logic [5:0] pop_x, pop_y;

  // One full row of the selected level; border cells are always wall.
  function automatic logic [MAP_W-1:0] pattern_row(input logic [1:0] lvl, input logic [5:0] y);
    logic [MAP_W-1:0] r;
    logic             border, pillar, bar, grid;
    int               yi;
    r  = '0;
    yi = int'(y);
    for (int x = 0; x < MAP_W; x++) begin
      border = (x == 0) || (x == MAP_W - 1) || (yi == 0) || (yi == MAP_H - 1);
      pillar = ((x == 16) || (x == 47)) && (yi >= 10) && (yi <= 33);
      bar    = (yi == 22) && (x >= 24) && (x <= 39);
      grid   = ((x % 8) == 4) && ((yi % 8) == 4);
      case (lvl)
        2'd0:    r[x[5:0]] = border;
        2'd1:    r[x[5:0]] = border | pillar;
        2'd2:    r[x[5:0]] = border | pillar | bar;
        default: r[x[5:0]] = border | grid;
      endcase
    end
    return r;
  endfunction

  assign run         = (state_q == S_RUN);
  assign full        = (count_q == Q_FULL);
  assign empty       = (count_q == '0);
  assign o_hit_ready = run && !full;
  assign o_ready     = run;
  assign o_is_wall   = is_wall_q;

  // i_init flushes the queue, so it also cancels any push or pop in that cycle.
  assign push      = i_hit_valid && o_hit_ready && !i_init;
  assign pop       = run && !i_buzy && !empty && !i_init;
  assign pop_x     = qx_q[rd_ptr_q];
  assign pop_y     = qy_q[rd_ptr_q];
  assign pop_clear = pop && (pop_y < Y_LIM) && (pop_x != 6'd0) && (pop_x != X_LAST)
                     && (pop_y != 6'd0) && (pop_y != Y_LAST);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    state_d = state_q;
    row_d   = row_q;
    level_d = level_q;
    if (i_init) begin
      state_d = S_BUILD;
      row_d   = '0;
      level_d = i_level;
    end else if (state_q == S_BUILD) begin
      if (row_q == Y_LAST) begin
        state_d = S_RUN;
        row_d   = '0;
      end else begin
        row_d = row_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      level_q <= level_d;
    end
  end

  // NOTE: the bitmap is reset because a cleared map is observable state; queue storage is not,
  // since entries are only read behind a valid count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < MAP_H; r++) map_q[r] <= '0;
      is_wall_q <= 1'b0;
    end else begin
      if (state_q == S_BUILD && !i_init) begin
        map_q[row_q] <= pattern_row(level_q, row_q);
      end else if (pop_clear) begin
        map_q[pop_y][pop_x] <= 1'b0;
      end
      is_wall_q <= (run && (i_request_y < Y_LIM)) ? map_q[i_request_y][i_request_x] : 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      qx_q[wr_ptr_q] <= i_hit_x;
      qy_q[wr_ptr_q] <= i_hit_y;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (i_init) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef WALL_MAP_CNT_EN
  logic [11:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (i_init) begin
      cnt_q <= '0;
    end else if (pop_clear && map_q[pop_y][pop_x] && (cnt_q != 12'hFFF)) begin
      cnt_q <= cnt_q + 12'd1;
    end
  end

  assign o_destroyed_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_wall_map.sv
// Self-checking bench for wall_map: cell-level reference model compared every cycle,
// plus hand-computed lookups. Define WALL_MAP_CNT_EN to also check o_destroyed_cnt.
module tb_wall_map;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_init = 1'b0;
  logic [1:0] i_level = 2'd0;
  logic       i_buzy = 1'b0;
  logic [5:0] i_request_x = 6'd0;
  logic [5:0] i_request_y = 6'd0;
  logic       i_hit_valid = 1'b0;
  logic [5:0] i_hit_x = 6'd0;
  logic [5:0] i_hit_y = 6'd0;
  logic       o_ready, o_is_wall, o_hit_ready;
`ifdef WALL_MAP_CNT_EN
  logic [11:0] o_destroyed_cnt;
`endif

  wall_map dut (
    .clk         (clk),
    .rst         (rst),
    .i_init      (i_init),
    .i_level     (i_level),
    .o_ready     (o_ready),
    .i_buzy      (i_buzy),
    .i_request_x (i_request_x),
    .i_request_y (i_request_y),
    .o_is_wall   (o_is_wall),
    .i_hit_valid (i_hit_valid),
    .i_hit_x     (i_hit_x),
    .i_hit_y     (i_hit_y),
    .o_hit_ready (o_hit_ready)
`ifdef WALL_MAP_CNT_EN
    ,
    .o_destroyed_cnt (o_destroyed_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: whole cells, whole queue ----------------
  typedef struct { int x; int y; } hit_t;

  bit   m_map [44][64];
  int   m_state;      // 0 idle, 1 building, 2 running
  int   m_bcycles;
  int   m_level;
  hit_t m_q [$];
  int   m_cnt;
  bit   exp_ready, exp_wall, exp_hit_ready;
  bit   model_live = 1'b0;

  function automatic bit level_cell(input int lvl, input int x, input int y);
    bit border = (x == 0) || (x == 63) || (y == 0) || (y == 43);
    bit pillar = (x == 16 || x == 47) && y >= 10 && y <= 33;
    bit bar    = (y == 22) && x >= 24 && x <= 39;
    bit grid   = (x % 8 == 4) && (y % 8 == 4);
    case (lvl)
      0:       return border;
      1:       return border || pillar;
      2:       return border || pillar || bar;
      default: return border || grid;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      foreach (m_map[y, x]) m_map[y][x] = 1'b0;
      m_state = 0; m_bcycles = 0; m_level = 0; m_cnt = 0;
      m_q.delete();
      exp_wall = 1'b0;
    end else begin
      bit running, do_push, do_pop;
      hit_t h;
      running  = (m_state == 2);
      exp_wall = (running && i_request_y < 44) ? m_map[i_request_y][i_request_x] : 1'b0;
      do_push  = i_hit_valid && running && (m_q.size() < 4);
      do_pop   = running && !i_buzy && (m_q.size() > 0);
      if (i_init) begin
        m_state = 1; m_bcycles = 0; m_level = int'(i_level); m_cnt = 0;
        m_q.delete();
      end else begin
        if (m_state == 1) begin
          m_bcycles++;
          if (m_bcycles == 44) begin
            foreach (m_map[y, x]) m_map[y][x] = level_cell(m_level, x, y);
            m_state = 2;
          end
        end
        if (do_pop) begin
          h = m_q.pop_front();
          if (h.y < 44 && h.x != 0 && h.x != 63 && h.y != 0 && h.y != 43) begin
            if (m_map[h.y][h.x] && m_cnt < 4095) m_cnt++;
            m_map[h.y][h.x] = 1'b0;
          end
        end
        if (do_push) begin
          h.x = int'(i_hit_x); h.y = int'(i_hit_y);
          m_q.push_back(h);
        end
      end
    end
    exp_ready     = (m_state == 2);
    exp_hit_ready = (m_state == 2) && (m_q.size() < 4);
  end

  always @(posedge clk) begin
    #2;
    if (model_live) begin
      check("model_ready", o_ready, exp_ready);
      check("model_is_wall", o_is_wall, exp_wall);
      check("model_hit_ready", o_hit_ready, exp_hit_ready);
`ifdef WALL_MAP_CNT_EN
      check("model_cnt", o_destroyed_cnt, m_cnt);
`endif
    end
  end

  // ---------------- stimulus tasks (all start and end at a negedge) ----------------
  task automatic do_init(input int lvl);
    int n;
    i_init  = 1'b1;
    i_level = 2'(lvl);
    @(posedge clk);
    #1 i_init = 1'b0;
    n = 0;
    while (!o_ready && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    check("ready_latency", n, 44);
    @(negedge clk);
  endtask

  task automatic start_init(input int lvl);
    i_init  = 1'b1;
    i_level = 2'(lvl);
    @(negedge clk);
    i_init = 1'b0;
  endtask

  task automatic lookup(input string name, input int x, input int y, input bit exp);
    i_request_x = 6'(x);
    i_request_y = 6'(y);
    @(posedge clk);
    #2 check(name, o_is_wall, exp);
    @(negedge clk);
  endtask

  task automatic send_hit(input int x, input int y);
    int k;
    i_hit_valid = 1'b1;
    i_hit_x     = 6'(x);
    i_hit_y     = 6'(y);
    k = 0;
    while (!o_hit_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k == 50) check("hit_accept_timeout", 0, 1);
    @(negedge clk);
    i_hit_valid = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    model_live = 1'b1;
    check("rst_ready", o_ready, 0);
    check("rst_is_wall", o_is_wall, 0);
    check("rst_hit_ready", o_hit_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // level 0: border only
    do_init(0);
    lookup("l0_0_5", 0, 5, 1);
    lookup("l0_10_10", 10, 10, 0);
    lookup("l0_63_43", 63, 43, 1);

    // level 1 pillars, level 3 grid, out-of-field row
    do_init(1);
    lookup("l1_16_10", 16, 10, 1);
    lookup("l1_16_9", 16, 9, 0);
    lookup("l1_47_33", 47, 33, 1);
    do_init(3);
    lookup("l3_4_4", 4, 4, 1);
    lookup("l3_5_4", 5, 4, 0);
    lookup("l3_y50", 4, 50, 0);

    // deferred write while buzy
    do_init(1);
    i_buzy = 1'b1;
    send_hit(16, 20);
    lookup("buzy_hold_a", 16, 20, 1);
    lookup("buzy_hold_b", 16, 20, 1);
    i_buzy = 1'b0;
    @(negedge clk);
    lookup("after_pop", 16, 20, 0);
`ifdef WALL_MAP_CNT_EN
    check("cnt_after_first", o_destroyed_cnt, 1);
`endif

    // fill the queue, 5th hit held until a pop frees a slot
    i_buzy = 1'b1;
    send_hit(16, 11);
    send_hit(16, 12);
    send_hit(16, 13);
    send_hit(16, 14);
    check("full_hit_ready", o_hit_ready, 0);
    fork
      send_hit(47, 11);
      begin
        repeat (3) @(negedge clk);
        i_buzy = 1'b0;
      end
    join
    repeat (8) @(negedge clk);
    lookup("drain_16_12", 16, 12, 0);
    lookup("drain_47_11", 47, 11, 0);
`ifdef WALL_MAP_CNT_EN
    check("cnt_after_drain", o_destroyed_cnt, 6);
`endif

    // border hit dropped, interior wall hit counted
    send_hit(0, 12);
    repeat (2) @(negedge clk);
    lookup("border_kept", 0, 12, 1);
`ifdef WALL_MAP_CNT_EN
    check("cnt_border", o_destroyed_cnt, 6);
`endif
    send_hit(47, 20);
    repeat (2) @(negedge clk);
    lookup("cleared_47_20", 47, 20, 0);
`ifdef WALL_MAP_CNT_EN
    check("cnt_47_20", o_destroyed_cnt, 7);
`endif

    // restart mid-BUILD, then mid-RUN with queued hits
    start_init(1);
    repeat (10) @(negedge clk);
    do_init(2);
    lookup("l2_30_22", 30, 22, 1);
    lookup("l2_23_22", 23, 22, 0);
    i_buzy = 1'b1;
    send_hit(30, 22);
    send_hit(31, 22);
    do_init(2);
    i_buzy = 1'b0;
    repeat (3) @(negedge clk);
    lookup("flushed_30_22", 30, 22, 1);
    lookup("flushed_31_22", 31, 22, 1);
`ifdef WALL_MAP_CNT_EN
    check("cnt_rebuilt", o_destroyed_cnt, 0);
`endif

    // reset mid-BUILD
    start_init(0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1 check("rst_mid_build_ready", o_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_ready", o_ready, 0);
    lookup("idle_lookup", 0, 5, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: actual running, required finished");
    $fatal(1);
  end

endmodule
